// File: rtl/imem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// imem_ctrl_pkg
// Shared definitions for the instruction-memory load controller:
//   - default parameter values (word width, address width, memory depth)
//   - FSM state encodings, kept as plain localparam constants so that
//     legacy tools and waveform viewers see stable 2-bit codes
//   - helper to derive the default memory depth from the address width
// No ports; imported by imem_load_ctrl and imem_ld_counter.
// -----------------------------------------------------------------------------
package imem_ctrl_pkg;

  // Default parameter values for the controller.
  localparam int DBITS_DEF = 32;
  localparam int ABITS_DEF = 32;

  // Default depth: one word per 1 KiB of address space.
  function automatic int words_for(input int abits);
    return 1 << (abits - 10);
  endfunction

  localparam int WORDS_DEF = 1 << (ABITS_DEF - 10);

  // FSM state encodings.
  typedef logic [1:0] state_t;

  localparam state_t ST_RUN  = 2'd0;  // CPU owns the memory, fetching at cpu_pc
  localparam state_t ST_LOAD = 2'd1;  // loader owns the memory, CPU stalled
  localparam state_t ST_DONE = 2'd2;  // single-cycle completion, CPU still stalled

endpackage : imem_ctrl_pkg

// File: rtl/imem_ld_counter.sv
// -----------------------------------------------------------------------------
// imem_ld_counter
// Address / remaining-word counter pair used while a program load is active.
// The address walks upward from the load base, the count walks down from the
// load length. Two status flags are derived from the registered values:
//   last_o : the current word is the final one of the load (count == 1)
//   ovf_o  : the current address lies past the end of the memory
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   synchronous active-high reset (clears both registers)
//   load_i  in   capture base_i / len_i
//   base_i  in   [ABITS] first word address of the load
//   len_i   in   [ABITS] number of words in the load
//   dec_i   in   one word transferred: address + 1, count - 1
//   addr_o  out  [ABITS] current write address
//   last_o  out  current word is the last of the load
//   ovf_o   out  current address >= WORDS
// -----------------------------------------------------------------------------
module imem_ld_counter
  import imem_ctrl_pkg::*;
#(
  parameter int ABITS = ABITS_DEF,
  parameter int WORDS = WORDS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [ABITS-1:0] base_i,
  input  logic [ABITS-1:0] len_i,
  input  logic             dec_i,
  output logic [ABITS-1:0] addr_o,
  output logic             last_o,
  output logic             ovf_o
);

  // One extra bit so that a depth equal to 2**ABITS still compares correctly.
  localparam logic [ABITS:0] WORDS_EXT = (ABITS+1)'(WORDS);

  logic [ABITS-1:0] addr_q, addr_d;
  logic [ABITS-1:0] cnt_q,  cnt_d;

  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      addr_d = base_i;
      cnt_d  = len_i;
    end else if (dec_i) begin
      // Address wrap at 2**ABITS is not handled: such a load is already
      // flagged by ovf_o long before the address could wrap.
      addr_d = addr_q + 1'b1;
      cnt_d  = cnt_q - 1'b1;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (cnt_q == ABITS'(1));
  assign ovf_o  = ({1'b0, addr_q} >= WORDS_EXT);

endmodule : imem_ld_counter

// File: rtl/imem_load_ctrl.sv
// -----------------------------------------------------------------------------
// imem_load_ctrl
// Arbitrates a single-port instruction memory between the CPU fetch path and
// a streaming program loader. In RUN the CPU fetches at cpu_pc. A load_start
// pulse in RUN hands the memory to the loader: the CPU is stalled, the loader
// streams words with a valid/ready handshake into consecutive addresses, and
// a one-cycle DONE state signals completion before the CPU resumes.
// Words that fall past the end of the memory are dropped and raise a sticky
// load_err flag that clears on the next accepted load or on reset.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   load_start  in   one-cycle load request (honoured in RUN only)
//   load_base   in   [ABITS] first word address, sampled with load_start
//   load_len    in   [ABITS] word count, sampled with load_start
//   wr_valid    in   loader word valid
//   wr_data     in   [DBITS] loader word
//   wr_ready    out  controller accepts the loader word this cycle
//   cpu_pc      in   [ABITS] CPU fetch address
//   cpu_stall   out  CPU must hold PC and state
//   load_done   out  one-cycle pulse at the end of a load
//   load_err    out  sticky: the load ran past WORDS-1
//   mem_en      out  instruction memory enable
//   mem_we      out  instruction memory write enable
//   mem_addr    out  [ABITS] instruction memory address
//   mem_din     out  [DBITS] instruction memory write data
// -----------------------------------------------------------------------------
module imem_load_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int DBITS = DBITS_DEF,
  parameter int ABITS = ABITS_DEF,
  parameter int WORDS = words_for(ABITS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic [ABITS-1:0] load_base,
  input  logic [ABITS-1:0] load_len,
  input  logic             wr_valid,
  input  logic [DBITS-1:0] wr_data,
  output logic             wr_ready,
  input  logic [ABITS-1:0] cpu_pc,
  output logic             cpu_stall,
  output logic             load_done,
  output logic             load_err,
  output logic             mem_en,
  output logic             mem_we,
  output logic [ABITS-1:0] mem_addr,
  output logic [DBITS-1:0] mem_din
);

  state_t state_q, state_d;
  logic   load_err_q, load_err_d;

  logic             accept_start;
  logic             len_nonzero;
  logic             xfer;
  logic [ABITS-1:0] addr_q;
  logic             last_word;
  logic             addr_ovf;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  // wr_ready comes from the registered state only, so the loader may make
  // wr_valid depend on wr_ready without forming a combinational loop. Reset
  // gates it so a reset cycle can never commit a word.
  assign wr_ready     = (state_q == ST_LOAD) && !rst;
  assign xfer         = wr_valid && wr_ready;

  // Start requests arriving in LOAD or DONE are ignored.
  assign accept_start = (state_q == ST_RUN) && load_start;
  assign len_nonzero  = (load_len != '0);

  // ---------------------------------------------------------------------------
  // Address / count pair
  // ---------------------------------------------------------------------------
  imem_ld_counter #(
    .ABITS (ABITS),
    .WORDS (WORDS)
  ) u_counter (
    .clk    (clk),
    .rst    (rst),
    .load_i (accept_start && len_nonzero),
    .base_i (load_base),
    .len_i  (load_len),
    .dec_i  (xfer),
    .addr_o (addr_q),
    .last_o (last_word),
    .ovf_o  (addr_ovf)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable assigned in this block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    load_err_d = load_err_q;
    case (state_q)
      ST_RUN: begin
        if (load_start) begin
          load_err_d = 1'b0;
          // A zero-length load skips straight to completion without writing.
          state_d    = len_nonzero ? ST_LOAD : ST_DONE;
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          if (addr_ovf) begin
            // Word is dropped; the remainder of the load is abandoned.
            load_err_d = 1'b1;
            state_d    = ST_DONE;
          end else if (last_word) begin
            state_d    = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_err_q <= load_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem_en    = 1'b1;
  assign mem_we    = xfer && !addr_ovf;
  assign mem_addr  = (state_q == ST_RUN) ? cpu_pc : addr_q;
  assign mem_din   = wr_data;

  // The CPU is held during reset as well as whenever the loader owns memory.
  assign cpu_stall = rst || (state_q != ST_RUN);
  assign load_done = !rst && (state_q == ST_DONE);
  assign load_err  = load_err_q;

endmodule : imem_load_ctrl

// File: tb/tb_imem_load_ctrl.sv
module tb_imem_load_ctrl;

  localparam int DBITS = 32;
  localparam int ABITS = 16;
  localparam int WORDS = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             load_start;
  logic [ABITS-1:0] load_base;
  logic [ABITS-1:0] load_len;
  logic             wr_valid;
  logic [DBITS-1:0] wr_data;
  logic             wr_ready;
  logic [ABITS-1:0] cpu_pc;
  logic             cpu_stall;
  logic             load_done;
  logic             load_err;
  logic             mem_en;
  logic             mem_we;
  logic [ABITS-1:0] mem_addr;
  logic [DBITS-1:0] mem_din;

  typedef struct packed {
    logic [ABITS-1:0] addr;
    logic [DBITS-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks   = 0;
  int  failures = 0;

  always #5 clk = ~clk;

  imem_load_ctrl #(
    .DBITS (DBITS),
    .ABITS (ABITS),
    .WORDS (WORDS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_base  (load_base),
    .load_len   (load_len),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .cpu_pc     (cpu_pc),
    .cpu_stall  (cpu_stall),
    .load_done  (load_done),
    .load_err   (load_err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din)
  );

  // Write scoreboard: every memory write seen mid-cycle must match the oldest
  // expected write pushed by the stimulus tasks.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h, expected no write", mem_addr, mem_din);
      end else begin
        mon_e = exp_q.pop_front();
        if (mem_addr !== mon_e.addr || mem_din !== mon_e.data) begin
          failures++;
          $display("FAIL write: got addr=%0h data=%0h, expected addr=%0h data=%0h",
                   mem_addr, mem_din, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  // Apply one cycle's inputs and let combinational outputs settle.
  task automatic drive(input logic r, input logic st, input logic [ABITS-1:0] base,
                       input logic [ABITS-1:0] len, input logic v, input logic [DBITS-1:0] d);
    rst = r; load_start = st; load_base = base; load_len = len; wr_valid = v; wr_data = d;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int addr, input logic [DBITS-1:0] data);
    exp_q.push_back('{addr: ABITS'(addr), data: data});
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drained: got %0d writes outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    cpu_pc = '0;
    drive(1'b1, 1'b0, '0, '0, 1'b1, 32'hDEAD_BEEF);
    checks++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL rst_stall: got %b expected 1", cpu_stall); end
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b expected 0", wr_ready); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_we: got %b expected 0", mem_we); end
    next_cycle();
    drive(1'b1, 1'b0, '0, '0, 1'b1, 32'hDEAD_BEEF);
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL post_rst_stall: got %b expected 0", cpu_stall); end
    checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL post_rst_done: got %b expected 0", load_done); end
    checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL post_rst_err: got %b expected 0", load_err); end
    checks++; if (mem_en !== 1'b1) begin failures++; $display("FAIL post_rst_en: got %b expected 1", mem_en); end
    next_cycle();
  endtask

  task automatic test_run_fetch();
    logic [ABITS-1:0] pcs [3] = '{16'd7, 16'h1234, 16'd0};
    for (int i = 0; i < 3; i++) begin
      cpu_pc = pcs[i];
      drive(1'b0, 1'b0, '0, '0, 1'b1, 32'h1111_0000 + DBITS'(i));
      checks++; if (mem_addr !== pcs[i]) begin failures++; $display("FAIL run_addr: got %0h expected %0h", mem_addr, pcs[i]); end
      checks++; if (mem_we !== 1'b0 || wr_ready !== 1'b0) begin failures++; $display("FAIL run_we_ready: got we=%b ready=%b expected 0 0", mem_we, wr_ready); end
      checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL run_stall: got %b expected 0", cpu_stall); end
      next_cycle();
    end
  endtask

  task automatic test_burst();
    cpu_pc = 16'd9;
    drive(1'b0, 1'b1, 16'd0, 16'd4, 1'b1, 32'hA0);
    checks++; if (mem_we !== 1'b0 || cpu_stall !== 1'b0) begin failures++; $display("FAIL burst_c0: got we=%b stall=%b expected 0 0", mem_we, cpu_stall); end
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1, 32'hA0 + DBITS'(k));
      push_exp(k, 32'hA0 + DBITS'(k));
      checks++; if (mem_we !== 1'b1 || wr_ready !== 1'b1 || cpu_stall !== 1'b1) begin
        failures++; $display("FAIL burst_c%0d: got we=%b ready=%b stall=%b expected 1 1 1", k + 1, mem_we, wr_ready, cpu_stall); end
      checks++; if (mem_addr !== ABITS'(k)) begin failures++; $display("FAIL burst_addr%0d: got %0h expected %0h", k, mem_addr, k); end
      next_cycle();
    end
    drive(1'b0, 1'b0, '0, '0, 1'b1, 32'hFF);
    checks++; if (load_done !== 1'b1 || cpu_stall !== 1'b1 || mem_we !== 1'b0 || wr_ready !== 1'b0) begin
      failures++; $display("FAIL burst_c5: got done=%b stall=%b we=%b ready=%b expected 1 1 0 0", load_done, cpu_stall, mem_we, wr_ready); end
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    checks++; if (cpu_stall !== 1'b0 || load_done !== 1'b0) begin failures++; $display("FAIL burst_c6: got stall=%b done=%b expected 0 0", cpu_stall, load_done); end
    check_drained("burst");
    next_cycle();
  endtask

  task automatic test_gapped();
    logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int   n = 0;
    drive(1'b0, 1'b1, 16'd10, 16'd3, 1'b0, '0);
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, '0, '0, pat[i], 32'hB0 + DBITS'(i));
      checks++; if (mem_addr !== ABITS'(10 + n)) begin failures++; $display("FAIL gap_addr%0d: got %0h expected %0h", i, mem_addr, 10 + n); end
      checks++; if (mem_we !== pat[i]) begin failures++; $display("FAIL gap_we%0d: got %b expected %b", i, mem_we, pat[i]); end
      if (pat[i]) begin
        push_exp(10 + n, 32'hB0 + DBITS'(i));
        n++;
      end
      next_cycle();
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    checks++; if (load_done !== 1'b1) begin failures++; $display("FAIL gap_done: got %b expected 1", load_done); end
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL gap_resume: got %b expected 0", cpu_stall); end
    check_drained("gapped");
    next_cycle();
  endtask

  task automatic test_overflow();
    drive(1'b0, 1'b1, ABITS'(WORDS - 2), 16'd4, 1'b1, 32'hC0);
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1, 32'hC0 + DBITS'(k));
      push_exp(WORDS - 2 + k, 32'hC0 + DBITS'(k));
      next_cycle();
    end
    drive(1'b0, 1'b0, '0, '0, 1'b1, 32'hC2);
    checks++; if (mem_we !== 1'b0 || wr_ready !== 1'b1) begin failures++; $display("FAIL ovf_drop: got we=%b ready=%b expected 0 1", mem_we, wr_ready); end
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 32'hC3);
    checks++; if (load_done !== 1'b1 || load_err !== 1'b1) begin failures++; $display("FAIL ovf_done: got done=%b err=%b expected 1 1", load_done, load_err); end
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    checks++; if (load_err !== 1'b1 || cpu_stall !== 1'b0) begin failures++; $display("FAIL ovf_sticky: got err=%b stall=%b expected 1 0", load_err, cpu_stall); end
    next_cycle();
    drive(1'b0, 1'b1, 16'd0, 16'd0, 1'b0, '0);
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    checks++; if (load_err !== 1'b0 || load_done !== 1'b1) begin failures++; $display("FAIL ovf_clear: got err=%b done=%b expected 0 1", load_err, load_done); end
    check_drained("overflow");
    next_cycle();
  endtask

  task automatic test_reset_abort();
    drive(1'b0, 1'b1, 16'd20, 16'd5, 1'b1, 32'hD0);
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1, 32'hD0 + DBITS'(k));
      push_exp(20 + k, 32'hD0 + DBITS'(k));
      next_cycle();
    end
    drive(1'b1, 1'b0, '0, '0, 1'b1, 32'hD2);
    checks++; if (mem_we !== 1'b0 || wr_ready !== 1'b0 || cpu_stall !== 1'b1) begin
      failures++; $display("FAIL abort_rst: got we=%b ready=%b stall=%b expected 0 0 1", mem_we, wr_ready, cpu_stall); end
    next_cycle();
    cpu_pc = 16'd3;
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1, 32'hD3 + DBITS'(k));
      checks++; if (cpu_stall !== 1'b0 || wr_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 16'd3) begin
        failures++; $display("FAIL abort_run%0d: got stall=%b ready=%b we=%b addr=%0h expected 0 0 0 3", k, cpu_stall, wr_ready, mem_we, mem_addr); end
      next_cycle();
    end
    check_drained("abort");
  endtask

  task automatic test_ignore_start();
    drive(1'b0, 1'b1, 16'd30, 16'd3, 1'b0, '0);
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 32'hE0);
    push_exp(30, 32'hE0);
    next_cycle();
    drive(1'b0, 1'b1, 16'd50, 16'd9, 1'b0, 32'hEE);
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL ign_idle_we: got %b expected 0", mem_we); end
    next_cycle();
    drive(1'b0, 1'b1, 16'd50, 16'd9, 1'b1, 32'hE1);
    push_exp(31, 32'hE1);
    checks++; if (mem_addr !== 16'd31) begin failures++; $display("FAIL ign_addr: got %0h expected 1f", mem_addr); end
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 32'hE2);
    push_exp(32, 32'hE2);
    next_cycle();
    drive(1'b0, 1'b1, 16'd0, 16'd2, 1'b1, 32'hE3);
    checks++; if (load_done !== 1'b1 || mem_we !== 1'b0) begin failures++; $display("FAIL ign_done: got done=%b we=%b expected 1 0", load_done, mem_we); end
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 32'hE4);
    checks++; if (cpu_stall !== 1'b0 || wr_ready !== 1'b0) begin failures++; $display("FAIL ign_done_start: got stall=%b ready=%b expected 0 0", cpu_stall, wr_ready); end
    check_drained("ignore");
    next_cycle();
  endtask

  task automatic test_zero_len();
    drive(1'b0, 1'b1, 16'd40, 16'd0, 1'b1, 32'hF0);
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL zero_c0_we: got %b expected 0", mem_we); end
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 32'hF1);
    checks++; if (load_done !== 1'b1 || mem_we !== 1'b0 || cpu_stall !== 1'b1 || wr_ready !== 1'b0) begin
      failures++; $display("FAIL zero_c1: got done=%b we=%b stall=%b ready=%b expected 1 0 1 0", load_done, mem_we, cpu_stall, wr_ready); end
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    checks++; if (cpu_stall !== 1'b0 || load_done !== 1'b0) begin failures++; $display("FAIL zero_c2: got stall=%b done=%b expected 0 0", cpu_stall, load_done); end
    check_drained("zero_len");
    next_cycle();
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b1, 16'd5, 16'd2, 1'b1, 32'h00);
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1, 32'h50 + DBITS'(k));
      push_exp(5 + k, 32'h50 + DBITS'(k));
      next_cycle();
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    next_cycle();
    drive(1'b0, 1'b1, 16'd8, 16'd1, 1'b0, '0);
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL b2b_gap: got stall=%b expected 0", cpu_stall); end
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 32'h5A);
    push_exp(8, 32'h5A);
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 32'h5B);
    checks++; if (load_done !== 1'b1 || mem_we !== 1'b0) begin failures++; $display("FAIL b2b_done: got done=%b we=%b expected 1 0", load_done, mem_we); end
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    check_drained("b2b");
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_run_fetch();
    test_burst();
    test_gapped();
    test_overflow();
    test_reset_abort();
    test_ignore_start();
    test_zero_len();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_imem_load_ctrl

// File: doc/imem_load_ctrl.md
IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 SHALL have parameter DBITS, default 32: instruction word width.
REQ-002 SHALL have parameter ABITS, default 32: address width.
REQ-003 SHALL have parameter WORDS, default 1<<(ABITS-10): instruction memory depth in words.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 load_start  input  1  one-cycle request to begin a program load.
REQ-008 load_base  input  ABITS  first word address of the load, sampled on the load_start cycle.
REQ-009 load_len  input  ABITS  word count of the load, sampled on the load_start cycle.
REQ-010 wr_valid  input  1  loader word valid.
REQ-011 wr_data  input  DBITS  loader word.
REQ-012 wr_ready  output  1  controller accepts the loader word this cycle.
REQ-013 cpu_pc  input  ABITS  CPU fetch address.
REQ-014 cpu_stall  output  1  CPU shall hold its PC and state.
REQ-015 load_done  output  1  one-cycle pulse at the end of a load.
REQ-016 load_err  output  1  sticky flag: the load ran past WORDS-1.
REQ-017 mem_en, mem_we  output  1 each  instruction memory enable and write enable.
REQ-018 mem_addr  output  ABITS  instruction memory address.
REQ-019 mem_din  output  DBITS  instruction memory write data.

Function
REQ-020 SHALL implement FSM states RUN, LOAD and DONE, with the state held in a register.
REQ-021 RUN: mem_en=1, mem_we=0, mem_addr=cpu_pc, cpu_stall=0, wr_ready=0.
REQ-022 RUN + load_start with load_len!=0 -> LOAD; addr_q<=load_base, cnt_q<=load_len, load_err<=0.
REQ-023 RUN + load_start with load_len==0 -> DONE, with no write; load_err<=0.
REQ-024 LOAD: cpu_stall=1 and wr_ready=1, driven from registered state only with no combinational path from wr_valid.
REQ-025 LOAD: a transfer occurs when wr_valid & wr_ready; on that cycle mem_we=1, mem_addr=addr_q, mem_din=wr_data, and the write commits at the same rising edge.
REQ-026 Each transfer SHALL do addr_q<=addr_q+1 (ABITS wrap ignored) and cnt_q<=cnt_q-1.
REQ-027 A transfer with cnt_q==1 -> DONE.
REQ-028 A transfer with addr_q>=WORDS SHALL force mem_we=0 (word dropped), set load_err=1, and go -> DONE.
REQ-029 LOAD with wr_valid=0: no write and no state change (unbounded wait).
REQ-030 load_start in LOAD or DONE SHALL be ignored.
REQ-031 DONE: lasts exactly 1 cycle; load_done=1, cpu_stall=1, mem_we=0, wr_ready=0, then -> RUN.
REQ-032 load_err SHALL stay set until the next accepted load_start or rst.
REQ-033 mem_en SHALL be 1 in every state outside reset.

Reset
REQ-034 rst SHALL force: state=RUN, addr_q=0, cnt_q=0, load_err=0, load_done=0.
REQ-035 During the rst cycle, mem_we=0, wr_ready=0 and cpu_stall=1.
REQ-036 Reset during LOAD SHALL abort the load with no further writes; words already written remain in memory.

Structure
REQ-037 State encodings (RUN=2'd0, LOAD=2'd1, DONE=2'd2) and the default parameter values SHALL live in the shared package/header imem_ctrl_pkg.
REQ-038 The address/count register pair MAY be a sub-module imem_ld_counter (load, decrement, last and overflow flags); everything else SHALL stay flat.

Verification
REQ-039 Load base=0, len=4, with wr_valid held high and data A0..A3 -> 4 consecutive writes to addresses 0..3, load_done pulses on cycle 5, cpu_stall falls on cycle 6.
REQ-040 Load len=3 with wr_valid gapped 1-0-1-0-1 -> exactly 3 writes, addresses incrementing only on valid cycles.
REQ-041 In RUN with cpu_pc=7 -> mem_addr=7, mem_we=0, cpu_stall=0.
REQ-042 Load base=WORDS-2, len=4 -> 2 writes, load_err=1, load_done pulses, and load_err clears on the next load_start.
REQ-043 Assert rst after 2 of 5 words -> next cycle state=RUN, no further mem_we, cpu_stall=0 after rst deasserts.
REQ-044 load_start pulsed mid-LOAD, and load_len=0 -> mid-LOAD start is ignored; len=0 gives load_done on the cycle after start with no write.
